operand_loader: RTL and testbench
=================================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 SHALL have parameter ADDER_WIDTH, default 116, the width of each assembled operand.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, the width of one inbound bus word; NW = ceil(ADDER_WIDTH/WORD_WIDTH), so NW = 4 at defaults.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous clear of any partial or held load.
REQ-006 SHALL have port in_valid  input  1  in_data carries a valid word.
REQ-007 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-008 SHALL have port in_data  input  WORD_WIDTH  inbound operand word.
REQ-009 SHALL have port out_valid  output  1  a/b hold a complete operand pair.
REQ-010 SHALL have port out_ready  input  1  the downstream adder stage takes the pair.
REQ-011 SHALL have port a  output  ADDER_WIDTH  assembled operand A, registered.
REQ-012 SHALL have port b  output  ADDER_WIDTH  assembled operand B, registered.
REQ-013 SHALL have port pad_err  output  1  sticky pad-bit error; present only under OPERAND_LOADER_PAD_CHECK_EN.

Function
REQ-014 SHALL accept a word only on a cycle with in_valid && in_ready (a beat).
REQ-015 SHALL run FSM states LOAD_A, LOAD_B and HOLD, plus a word counter 0..NW-1.
REQ-016 SHALL, in LOAD_A, write beat k into a[k*WORD_WIDTH +: WORD_WIDTH], truncated at bit ADDER_WIDTH-1; LSW first.
REQ-017 SHALL move LOAD_A->LOAD_B on beat NW-1 and clear the counter; LOAD_B fills b identically.
REQ-018 SHALL move LOAD_B->HOLD on beat NW-1; out_valid SHALL be 1 in the next cycle (1-cycle latency from the last beat).
REQ-019 SHALL drive in_ready=1 in LOAD_A/LOAD_B and 0 in HOLD; out_valid=1 only in HOLD.
REQ-020 SHALL hold a and b stable throughout HOLD; HOLD->LOAD_A on out_valid && out_ready, with no beat accepted in that cycle.
REQ-021 SHALL ignore pad bits of the last word (bits ADDER_WIDTH-(NW-1)*WORD_WIDTH .. WORD_WIDTH-1, i.e. 20..31 at defaults).
REQ-022 SHALL, on flush, go to LOAD_A, zero the counter, a and b, and drop any beat or handshake in that cycle; flush has priority over all events.
REQ-023 SHALL keep the state and counter unchanged while in_valid=0 (stalls of any length).
REQ-024 SHALL leave a and b unchanged when out_valid && out_ready fires; the next load overwrites them word by word.

Reset
REQ-025 SHALL, while rst_n=0, force state LOAD_A, counter 0, a=0, b=0, out_valid=0, in_ready=1 and pad_err=0.
REQ-026 SHALL discard any partial load interrupted by reset; the first beat after release is word 0 of A.

Configuration
REQ-027 SHALL, with OPERAND_LOADER_PAD_CHECK_EN defined, set pad_err sticky when any pad bit of a last-word beat is 1; only reset or flush clears it.
REQ-028 SHALL, without OPERAND_LOADER_PAD_CHECK_EN, omit pad_err and the check logic entirely; all other behaviour is identical.

Structure
REQ-029 SHALL place the state enum, the NW computation and the pad-mask constant in package operand_loader_pkg.
REQ-030 SHALL use one sub-module, operand_assembler (counter-indexed word writer with pad masking), instantiated once for a and once for b.

Verification
REQ-031 SHALL cover: 8 back-to-back beats 0x1..0x8, out_ready=1 -> a=0x0000_0004_0000_0003_0000_0002_0000_0001 (pad bits masked, value 4 in word 3), b built from 5..8, out_valid exactly 1 cycle, in_ready=0 during HOLD.
REQ-032 SHALL cover: out_ready held 0 for 10 cycles in HOLD with in_valid=1 -> a/b stable, no beats accepted, release -> LOAD_A.
REQ-033 SHALL cover: flush after 5 beats -> a=b=0, next 8 beats assemble a fresh pair correctly.
REQ-034 SHALL cover: rst_n pulsed low after 3 beats -> all outputs at reset values, next beat lands in a[31:0].
REQ-035 SHALL cover: with the macro defined, last word of A = 0xFFF0_0000 -> pad_err=1 stays set through HOLD and the next load, cleared by flush.
REQ-036 SHALL cover: random in_valid gaps (about 50 percent) -> assembled a/b match a reference model over 1000 pairs.

Source files
------------

// File: rtl/operand_loader_pkg.sv
// ============================================================================
// Module : operand_loader_pkg
// Brief  : Shared state encoding and sizing helpers for the operand loader.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package operand_loader_pkg;

    localparam int MAX_WORD_WIDTH = 256;

    typedef logic [1:0] state_t;

    localparam state_t ST_LOAD_A = 2'd0;
    localparam state_t ST_LOAD_B = 2'd1;
    localparam state_t ST_HOLD   = 2'd2;

    function automatic int calc_nw(input int aw, input int ww);
        return (aw + ww - 1) / ww;
    endfunction

    function automatic int calc_cnt_w(input int aw, input int ww);
        return (calc_nw(aw, ww) > 1) ? $clog2(calc_nw(aw, ww)) : 1;
    endfunction

    // Number of meaningful bits in the most significant word of an operand.
    function automatic int calc_last_bits(input int aw, input int ww);
        return aw - (calc_nw(aw, ww) - 1) * ww;
    endfunction

    function automatic logic [MAX_WORD_WIDTH-1:0] calc_pad_mask(input int aw, input int ww);
        logic [MAX_WORD_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_WORD_WIDTH; i++) begin
            mask[i] = (i >= calc_last_bits(aw, ww)) && (i < ww);
        end
        return mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/operand_assembler.sv
// ============================================================================
// Module : operand_assembler
// Brief  : Counter-indexed word writer building one operand; pad bits of the
//          top word are dropped by storing only its meaningful bits.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_assembler
    import operand_loader_pkg::*;
#(
    parameter int ADDER_WIDTH = 116,
    parameter int WORD_WIDTH  = 32
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           clr_i,
    input  logic                                           wr_en_i,
    input  logic [calc_cnt_w(ADDER_WIDTH, WORD_WIDTH)-1:0] idx_i,
    input  logic [WORD_WIDTH-1:0]                          word_i,
    output logic [ADDER_WIDTH-1:0]                         value_o
);

    localparam int NW        = calc_nw(ADDER_WIDTH, WORD_WIDTH);
    localparam int CNT_W     = calc_cnt_w(ADDER_WIDTH, WORD_WIDTH);
    localparam int LAST_BITS = calc_last_bits(ADDER_WIDTH, WORD_WIDTH);

    for (genvar k = 0; k < NW; k++) begin : g_word
        localparam int              W   = (k == NW - 1) ? LAST_BITS : WORD_WIDTH;
        localparam logic [CNT_W-1:0] IDX = CNT_W'(k);

        logic [W-1:0] word_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_q <= '0;
            end else if (clr_i) begin
                word_q <= '0;
            end else if (wr_en_i && (idx_i == IDX)) begin
                word_q <= word_i[W-1:0];
            end
        end

        assign value_o[k*WORD_WIDTH +: W] = word_q;
    end

endmodule

`default_nettype wire

// File: rtl/operand_loader.sv
// ============================================================================
// Module : operand_loader
// Brief  : Serial-to-parallel loader assembling operand pair a/b from bus
//          words for the adder stage. Optional sticky pad-bit check enabled
//          by defining OPERAND_LOADER_PAD_CHECK_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int ADDER_WIDTH = 116,
    parameter int WORD_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef OPERAND_LOADER_PAD_CHECK_EN
    output logic                   pad_err,
`endif
    output logic [ADDER_WIDTH-1:0] a,
    output logic [ADDER_WIDTH-1:0] b
);

    localparam int               NW       = calc_nw(ADDER_WIDTH, WORD_WIDTH);
    localparam int               CNT_W    = calc_cnt_w(ADDER_WIDTH, WORD_WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NW - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_we, b_we;

    assign in_ready  = (state_q != ST_HOLD);
    assign out_valid = (state_q == ST_HOLD);

    // in_ready is high in both load states, so in_valid alone marks a beat there.
    assign a_we = !flush && in_valid && (state_q == ST_LOAD_A);
    assign b_we = !flush && in_valid && (state_q == ST_LOAD_B);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = ST_LOAD_A;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_LOAD_A, ST_LOAD_B: begin
                    if (in_valid) begin
                        if (cnt_q == LAST_IDX) begin
                            cnt_d   = '0;
                            state_d = (state_q == ST_LOAD_A) ? ST_LOAD_B : ST_HOLD;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_d = ST_LOAD_A;
                    end
                end
                default: begin
                    state_d = ST_LOAD_A;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD_A;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    operand_assembler #(
        .ADDER_WIDTH (ADDER_WIDTH),
        .WORD_WIDTH  (WORD_WIDTH)
    ) u_asm_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (flush),
        .wr_en_i (a_we),
        .idx_i   (cnt_q),
        .word_i  (in_data),
        .value_o (a)
    );

    operand_assembler #(
        .ADDER_WIDTH (ADDER_WIDTH),
        .WORD_WIDTH  (WORD_WIDTH)
    ) u_asm_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (flush),
        .wr_en_i (b_we),
        .idx_i   (cnt_q),
        .word_i  (in_data),
        .value_o (b)
    );

`ifdef OPERAND_LOADER_PAD_CHECK_EN
    localparam logic [WORD_WIDTH-1:0] PAD_MASK =
        WORD_WIDTH'(calc_pad_mask(ADDER_WIDTH, WORD_WIDTH));

    logic pad_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_err_q <= 1'b0;
        end else if (flush) begin
            pad_err_q <= 1'b0;
        end else if ((a_we || b_we) && (cnt_q == LAST_IDX) && |(in_data & PAD_MASK)) begin
            pad_err_q <= 1'b1;
        end
    end

    assign pad_err = pad_err_q;
`else
    // Pad bits of the top word are dropped silently by the assemblers.
`endif

endmodule

`default_nettype wire

// File: tb/tb_operand_loader.sv
// ============================================================================
// Module : tb_operand_loader
// Brief  : Self-checking bench for operand_loader against a word-array model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_operand_loader;

    localparam int AW        = 116;
    localparam int WW        = 32;
    localparam int NW        = 4;
    localparam int LAST_BITS = AW - (NW - 1) * WW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [WW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
`ifdef OPERAND_LOADER_PAD_CHECK_EN
    logic          pad_err;
`endif

    always #5 clk = ~clk;

    operand_loader #(
        .ADDER_WIDTH (AW),
        .WORD_WIDTH  (WW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef OPERAND_LOADER_PAD_CHECK_EN
        .pad_err   (pad_err),
`endif
        .a         (a),
        .b         (b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: the words of each operand as an array, a count of
    // words taken for the current pair, and a hold flag.
    logic [WW-1:0] wa [NW];
    logic [WW-1:0] wb [NW];
    int            m_n;
    bit            m_hold;
    bit            m_pad;
    int            pairs;

    function automatic logic [AW-1:0] pack(input logic [WW-1:0] w [NW]);
        logic [127:0] t;
        t = '0;
        for (int i = 0; i < NW; i++) begin
            t = t | ({96'b0, w[i]} << (WW * i));
        end
        return t[AW-1:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin
            wa[i] = '0;
            wb[i] = '0;
        end
        m_n    = 0;
        m_hold = 1'b0;
        m_pad  = 1'b0;
    endtask

    task automatic model_clock(input logic f, input logic v, input logic [WW-1:0] d, input logic r);
        if (f) begin
            model_reset();
        end else if (m_hold) begin
            if (r) begin
                m_hold = 1'b0;
                pairs++;
            end
        end else if (v) begin
            if (m_n < NW) wa[m_n] = d;
            else          wb[m_n - NW] = d;
            if ((m_n % NW) == NW - 1 && (d >> LAST_BITS) != 0) m_pad = 1'b1;
            m_n++;
            if (m_n == 2 * NW) begin
                m_n    = 0;
                m_hold = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check("in_ready", in_ready, !m_hold);
        check("out_valid", out_valid, m_hold);
        check("a", a, pack(wa));
        check("b", b, pack(wb));
`ifdef OPERAND_LOADER_PAD_CHECK_EN
        check("pad_err", pad_err, m_pad);
`endif
    endtask

    // Called at a negedge: check, drive, clock, update the model.
    task automatic step(input logic f, input logic v, input logic [WW-1:0] d, input logic r);
        check_outputs();
        flush     = f;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        model_clock(f, v, d, r);
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        pairs     = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back pair 1..8 with out_ready high.
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, WW'(i), 1'b1);
        check("t1_a", a, 116'h4_0000_0003_0000_0002_0000_0001);
        check("t1_b", b, 116'h8_0000_0007_0000_0006_0000_0005);
        check("t1_out_valid", out_valid, 1);
        check("t1_in_ready", in_ready, 0);
        step(1'b0, 1'b0, '0, 1'b1);
        check("t1_valid_one_cycle", out_valid, 0);

        // Downstream stall in HOLD with in_valid asserted.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, $urandom, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, $urandom, 1'b0);
        check("t2_hold_valid", out_valid, 1);
        step(1'b0, 1'b1, 32'h1234_5678, 1'b1);
        check("t2_released", in_ready, 1);

        // Flush after 5 beats, then a fresh pair.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, $urandom, 1'b0);
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        check("t3_flush_a", a, 0);
        check("t3_flush_b", b, 0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, $urandom, 1'b0);
        check("t3_hold", out_valid, 1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Asynchronous reset after 3 beats.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, $urandom, 1'b0);
        check_outputs();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("t4_rst_a", a, 0);
        check("t4_rst_b", b, 0);
        check("t4_rst_in_ready", in_ready, 1);
        check("t4_rst_out_valid", out_valid, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 32'hCAFE_0001, 1'b0);
        check("t4_first_word", a[31:0], 32'hCAFE_0001);
        check("t4_a_upper", a[AW-1:32], 0);

`ifdef OPERAND_LOADER_PAD_CHECK_EN
        // Sticky pad error: set by A's top word, held through HOLD and the next load.
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'hFFF0_0000, 1'b0);
        check("t5_pad_set", pad_err, 1);
        check("t5_pad_masked", a[AW-1:96], 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h1, 1'b0);
        check("t5_pad_hold", pad_err, 1);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 32'h5, 1'b0);
        check("t5_pad_next", pad_err, 1);
        step(1'b1, 1'b0, '0, 1'b0);
        check("t5_pad_clr", pad_err, 0);
`endif

        // Random traffic against the model.
        pairs = 0;
        cyc   = 0;
        while (pairs < 1000 && cyc < 60000) begin
            step(($urandom_range(0, 299) == 0), $urandom_range(0, 1) == 1,
                 $urandom, $urandom_range(0, 1) == 1);
            cyc++;
        end
        check_outputs();
        check("rand_pairs_done", pairs >= 1000, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
